mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single main-memory line port between the iCache refill path and the dCache refill/write-back path. Each requester holds a line request; the arbiter grants one at a time, drives the memory handshake, latches the returned line and pulses a per-requester done. Sits between the two caches and the memory model in the monocycle core.

## Interface
- ADDR_WIDTH, 32, line address width (byte address; bits [3:0] ignored, forwarded as zero)
- LINE_WIDTH, 128, cache line width in bits

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; flushes arbiter state
- i_req  in  1  iCache line-fill request, held until i_done
- i_addr  in  ADDR_WIDTH  iCache miss address, stable while i_req high
- i_done  out  1  one-cycle pulse: i_line valid
- i_line  out  LINE_WIDTH  fill data for iCache
- d_req  in  1  dCache request, held until d_done
- d_we  in  1  1 = line write-back, 0 = line fill; stable while d_req high
- d_addr  in  ADDR_WIDTH  dCache line address
- d_wdata  in  LINE_WIDTH  write-back data
- d_done  out  1  one-cycle pulse: write accepted or d_line valid
- d_line  out  LINE_WIDTH  fill data for dCache
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory line address, [3:0] = 0
- mem_wdata  out  LINE_WIDTH  memory write data
- mem_rdata  in  LINE_WIDTH  memory read data, valid with mem_ready on reads
- mem_ready  in  1  one-cycle pulse: memory completed current access

## Operation
- States: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE: if neither req, stay. Only i_req -> SERVE_I. Only d_req -> SERVE_D. Both -> round-robin: grant the requester not served last; `last_d` register, reset 0, so dCache wins the first tie.
- On grant: latch address (low 4 bits cleared), d_we and d_wdata into internal registers; drive mem_req=1 and mem_we/mem_addr/mem_wdata from the latched copies. iCache grants always mem_we=0, mem_wdata=0.
- SERVE_x: hold mem_* stable; on mem_ready: latch mem_rdata into i_line (SERVE_I) or d_line (SERVE_D, reads only; writes leave d_line unchanged), drop mem_req, assert the matching done, update last_d, -> DONE.
- DONE: done high this cycle only; -> IDLE. Requester drops req on the edge closing this cycle; arbiter ignores req levels sampled in DONE.
- i_line/d_line hold their value until the next fill for that requester.
- mem_ready outside SERVE_x is ignored.
- Changes to a requester's address/data while it is granted have no effect (latched copies used).

## Timing
- Reset values: state IDLE, last_d 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, i_done 0, d_done 0, i_line 0, d_line 0.
- All outputs registered.
- Request seen in IDLE at cycle 0 -> mem_req high cycle 1.
- mem_ready at cycle k (k>=1) -> mem_req low and done/line valid at cycle k+1 -> IDLE at k+2 -> earliest next mem_req at k+3.
- Minimum request-to-done latency: 2 cycles (mem_ready in cycle 1). No upper bound; arbiter waits indefinitely on mem_ready.
- Losing requester keeps req high and is granted in the IDLE immediately after the winner's DONE (no starvation: at most one foreign transaction in between).
- Reset mid-transaction: next cycle all outputs at reset values, state IDLE, no done pulse, outstanding access abandoned (memory shares same reset). Reset dominates a coincident mem_ready.

## Test plan
- Single iCache fill: reset, i_req=1, i_addr=0x0000_0047, memory returns mem_ready at cycle 3 with 0xAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD -> mem_addr=0x40, mem_we=0, i_done pulse cycle 4, i_line equals data, d_done never asserts.
- dCache write-back: d_req=1, d_we=1, d_addr=0x100, d_wdata=0x1111…(128 bits) -> mem_we=1, mem_wdata matches, d_done pulse after mem_ready, d_line unchanged (0).
- Simultaneous requests after reset: i_req and d_req same cycle -> dCache served first, iCache mem_req rises 2 cycles after d_done; repeat tie -> iCache served first (round-robin alternation).
- Back-to-back fairness: dCache re-raises d_req immediately after each d_done while i_req stays high -> grants alternate D, I, D, I.
- Reset mid-operation: assert reset while SERVE_I and mem_ready high same cycle -> next cycle mem_req=0, i_done=0, i_line=0, state IDLE; fresh i_req then served normally.
- Stray/stable checks: mem_ready pulse in IDLE -> no done; i_addr changed during SERVE_I -> mem_addr unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-way arbiter sharing the memory line port between iCache fills and
// dCache fills/write-backs, with round-robin tie-breaking and registered outputs.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_done,
    output logic [LINE_WIDTH-1:0] i_line,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic                  d_done,
    output logic [LINE_WIDTH-1:0] d_line,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  last_d_q, last_d_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  i_done_q, i_done_d;
    logic                  d_done_q, d_done_d;
    logic [LINE_WIDTH-1:0] i_line_q, i_line_d;
    logic [LINE_WIDTH-1:0] d_line_q, d_line_d;

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_line_q    <= '0;
            d_line_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            i_line_q    <= i_line_d;
            d_line_q    <= d_line_d;
        end
    end

    // Next state: a tie goes to whichever requester was not served last
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (d_req && (!i_req || !last_d_q)) begin
                    state_d = SERVE_D;
                end else if (i_req) begin
                    state_d = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_ready) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next-values; the mem_* registers double as the latched request copy
    always_comb begin
        last_d_d    = last_d_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        i_line_d    = i_line_q;
        d_line_d    = d_line_q;
        unique case (state_q)
            IDLE: begin
                if (state_d == SERVE_D) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = {d_addr[ADDR_WIDTH-1:4], 4'b0000};
                    mem_wdata_d = d_wdata;
                end else if (state_d == SERVE_I) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = {i_addr[ADDR_WIDTH-1:4], 4'b0000};
                    mem_wdata_d = '0;
                end
            end
            SERVE_I: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    i_line_d  = mem_rdata;
                    i_done_d  = 1'b1;
                    last_d_d  = 1'b0;
                end
            end
            SERVE_D: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        d_line_d = mem_rdata;
                    end
                    d_done_d = 1'b1;
                    last_d_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign i_line    = i_line_q;
    assign d_line    = d_line_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single fills, write-back, tie-breaking,
// alternation under sustained load, stray mem_ready and mid-transaction reset.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;

    logic          clk;
    logic          reset;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_done;
    logic [LW-1:0] i_line;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_wdata;
    logic          d_done;
    logic [LW-1:0] d_line;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_ready;

    int vectors_applied = 0;
    int miscompares     = 0;

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_done   (i_done),
        .i_line   (i_line),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_done   (d_done),
        .d_line   (d_line),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        vectors_applied++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Memory model: wait 'delay' cycles with mem_req held, then one mem_ready pulse
    task automatic mem_respond(input int delay, input logic [LW-1:0] data);
        for (int w = 0; w < delay; w++) begin
            tick();
            check_vec("mem_req_held", {127'b0, mem_req}, 128'd1);
        end
        mem_ready = 1'b1;
        mem_rdata = data;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
    endtask

    localparam logic [LW-1:0] DATA_A = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
    localparam logic [LW-1:0] DATA_B = 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE;
    localparam logic [LW-1:0] WB_DAT = {32{4'h1}};

    initial begin
        logic [LW-1:0] fill;
        logic          exp_d;
        logic [LW-1:0] last_i_line;
        logic [LW-1:0] last_d_line;

        reset = 1'b1; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        do_reset();

        // Reset values
        check_vec("rst_mem_req",   {127'b0, mem_req}, 128'd0);
        check_vec("rst_mem_we",    {127'b0, mem_we},  128'd0);
        check_vec("rst_mem_addr",  {96'b0, mem_addr}, 128'd0);
        check_vec("rst_mem_wdata", mem_wdata,         128'd0);
        check_vec("rst_i_done",    {127'b0, i_done},  128'd0);
        check_vec("rst_d_done",    {127'b0, d_done},  128'd0);
        check_vec("rst_i_line",    i_line,            128'd0);
        check_vec("rst_d_line",    d_line,            128'd0);

        // Single iCache fill, address low nibble cleared, address change ignored
        i_addr = 32'h0000_0047;
        i_req  = 1'b1;
        tick();
        check_vec("i1_mem_req",   {127'b0, mem_req}, 128'd1);
        check_vec("i1_mem_addr",  {96'b0, mem_addr}, 128'h40);
        check_vec("i1_mem_we",    {127'b0, mem_we},  128'd0);
        check_vec("i1_mem_wdata", mem_wdata,         128'd0);
        i_addr = 32'h1234_5678;
        tick();
        check_vec("i1_addr_stable", {96'b0, mem_addr}, 128'h40);
        mem_respond(1, DATA_A);
        check_vec("i1_done",    {127'b0, i_done},  128'd1);
        check_vec("i1_line",    i_line,            DATA_A);
        check_vec("i1_req_low", {127'b0, mem_req}, 128'd0);
        check_vec("i1_no_ddone", {127'b0, d_done}, 128'd0);
        i_req = 1'b0;
        tick();
        check_vec("i1_done_pulse", {127'b0, i_done}, 128'd0);
        check_vec("i1_line_hold",  i_line,           DATA_A);

        // Stray mem_ready while idle
        mem_ready = 1'b1;
        mem_rdata = DATA_B;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        check_vec("stray_i_done",  {127'b0, i_done},  128'd0);
        check_vec("stray_d_done",  {127'b0, d_done},  128'd0);
        check_vec("stray_mem_req", {127'b0, mem_req}, 128'd0);
        tick();
        check_vec("stray_i_line", i_line, DATA_A);
        check_vec("stray_d_line", d_line, 128'd0);

        // dCache write-back: d_line must not change
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = WB_DAT;
        tick();
        check_vec("wb_mem_req",   {127'b0, mem_req}, 128'd1);
        check_vec("wb_mem_we",    {127'b0, mem_we},  128'd1);
        check_vec("wb_mem_addr",  {96'b0, mem_addr}, 128'h100);
        check_vec("wb_mem_wdata", mem_wdata,         WB_DAT);
        d_wdata = '0;
        tick();
        check_vec("wb_wdata_stable", mem_wdata, WB_DAT);
        mem_respond(0, DATA_B);
        check_vec("wb_d_done", {127'b0, d_done}, 128'd1);
        check_vec("wb_d_line", d_line,           128'd0);
        check_vec("wb_i_done", {127'b0, i_done}, 128'd0);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        check_vec("wb_done_pulse", {127'b0, d_done}, 128'd0);

        // Tie after reset: dCache first, iCache grant two cycles after d_done
        do_reset();
        i_req = 1'b1; i_addr = 32'h0000_0200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_030C;
        tick();
        check_vec("tie_d_addr", {96'b0, mem_addr}, 128'h300);
        check_vec("tie_d_we",   {127'b0, mem_we},  128'd0);
        mem_respond(0, DATA_A);
        check_vec("tie_d_done", {127'b0, d_done}, 128'd1);
        check_vec("tie_d_line", d_line,           DATA_A);
        check_vec("tie_i_wait", {127'b0, i_done}, 128'd0);
        d_req = 1'b0;
        tick();
        check_vec("tie_gap_req", {127'b0, mem_req}, 128'd0);
        tick();
        check_vec("tie_i_req",  {127'b0, mem_req}, 128'd1);
        check_vec("tie_i_addr", {96'b0, mem_addr}, 128'h200);
        mem_respond(0, DATA_B);
        check_vec("tie_i_done", {127'b0, i_done}, 128'd1);
        check_vec("tie_i_line", i_line,           DATA_B);
        check_vec("tie_d_keep", d_line,           DATA_A);
        i_req = 1'b0;
        tick();

        // Sustained load from both sides: grants alternate D, I, D, I
        last_i_line = DATA_B;
        last_d_line = DATA_A;
        i_req = 1'b1; i_addr = 32'h0000_0400;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0800;
        for (int n = 0; n < 4; n++) begin
            exp_d = (n % 2 == 0);
            fill  = {4{32'hF000_0000 + 32'(n)}};
            tick();
            check_vec("alt_mem_req",  {127'b0, mem_req}, 128'd1);
            check_vec("alt_mem_addr", {96'b0, mem_addr}, exp_d ? 128'h800 : 128'h400);
            mem_respond(n, fill);
            if (exp_d) last_d_line = fill;
            else       last_i_line = fill;
            check_vec("alt_d_done", {127'b0, d_done}, {127'b0, exp_d});
            check_vec("alt_i_done", {127'b0, i_done}, {127'b0, ~exp_d});
            check_vec("alt_i_line", i_line, last_i_line);
            check_vec("alt_d_line", d_line, last_d_line);
            tick();
            check_vec("alt_idle_req", {127'b0, mem_req}, 128'd0);
        end
        i_req = 1'b0;
        d_req = 1'b0;

        // dCache alone, then a tie: iCache now wins
        d_req = 1'b1; d_addr = 32'h0000_0900;
        tick();
        check_vec("rr_d_addr", {96'b0, mem_addr}, 128'h900);
        mem_respond(0, DATA_A);
        check_vec("rr_d_done", {127'b0, d_done}, 128'd1);
        d_req = 1'b0;
        tick();
        i_req = 1'b1; i_addr = 32'h0000_0A00;
        d_req = 1'b1; d_addr = 32'h0000_0B00;
        tick();
        check_vec("rr_tie_i_first", {96'b0, mem_addr}, 128'hA00);
        mem_respond(0, DATA_B);
        check_vec("rr_i_done", {127'b0, i_done}, 128'd1);
        i_req = 1'b0;
        tick();
        tick();
        check_vec("rr_then_d", {96'b0, mem_addr}, 128'hB00);
        mem_respond(0, WB_DAT);
        check_vec("rr_d_line", d_line, WB_DAT);
        d_req = 1'b0;
        tick();

        // Reset during SERVE_I with coincident mem_ready
        i_req = 1'b1; i_addr = 32'h0000_0C00;
        tick();
        check_vec("mr_mem_req", {127'b0, mem_req}, 128'd1);
        reset = 1'b1; mem_ready = 1'b1; mem_rdata = DATA_A; i_req = 1'b0;
        tick();
        reset = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        check_vec("mr_req_clr",  {127'b0, mem_req}, 128'd0);
        check_vec("mr_i_done",   {127'b0, i_done},  128'd0);
        check_vec("mr_i_line",   i_line,            128'd0);
        check_vec("mr_d_line",   d_line,            128'd0);
        check_vec("mr_mem_addr", {96'b0, mem_addr}, 128'd0);
        tick();
        check_vec("mr_no_late_done", {127'b0, i_done}, 128'd0);
        i_req = 1'b1; i_addr = 32'h0000_0D05;
        tick();
        check_vec("mr_fresh_req",  {127'b0, mem_req}, 128'd1);
        check_vec("mr_fresh_addr", {96'b0, mem_addr}, 128'hD00);
        mem_respond(1, DATA_B);
        check_vec("mr_fresh_done", {127'b0, i_done}, 128'd1);
        check_vec("mr_fresh_line", i_line,           DATA_B);
        i_req = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
